axi_master_port: RTL

Generic AXI4 master port for the CPU side of the bus: converts one core memory request (single word or INCR burst, read or write) into a full AXI read or write transaction. It is the counterpart to the slave-side memory wrappers and drives one master slot of the AXI interconnect. Requests are strictly serialised: one outstanding transaction at a time.

---
 rtl/axi_master_port.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_master_port.sv
//==============================================================================
// Module   : axi_master_port
// Purpose  : Serialised core-request to AXI4 master bridge (single/INCR burst).
//            Optional sticky error flag enabled by AXI_MASTER_ERR_STICKY_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module axi_master_port #(
   parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [`AXI_ADDR_BITS-1:0]  req_addr,
   input  logic [`AXI_LEN_BITS-1:0]   req_len,
   input  logic [`AXI_DATA_BITS-1:0]  wd_data,
   input  logic [`AXI_STRB_BITS-1:0]  wd_strb,
   input  logic                       wd_valid,
   output logic                       wd_ready,
   output logic [`AXI_DATA_BITS-1:0]  rd_data,
   output logic                       rd_last,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic                       done,
   output logic                       err,
   input  logic                       err_clr,
   output logic [`AXI_ID_BITS-1:0]    ARID_M,
   output logic [`AXI_ADDR_BITS-1:0]  ARADDR_M,
   output logic [`AXI_LEN_BITS-1:0]   ARLEN_M,
   output logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M,
   output logic [1:0]                 ARBURST_M,
   output logic                       ARVALID_M,
   input  logic                       ARREADY_M,
   input  logic [`AXI_ID_BITS-1:0]    RID_M,
   input  logic [`AXI_DATA_BITS-1:0]  RDATA_M,
   input  logic [1:0]                 RRESP_M,
   input  logic                       RLAST_M,
   input  logic                       RVALID_M,
   output logic                       RREADY_M,
   output logic [`AXI_ID_BITS-1:0]    AWID_M,
   output logic [`AXI_ADDR_BITS-1:0]  AWADDR_M,
   output logic [`AXI_LEN_BITS-1:0]   AWLEN_M,
   output logic [`AXI_SIZE_BITS-1:0]  AWSIZE_M,
   output logic [1:0]                 AWBURST_M,
   output logic                       AWVALID_M,
   input  logic                       AWREADY_M,
   output logic [`AXI_DATA_BITS-1:0]  WDATA_M,
   output logic [`AXI_STRB_BITS-1:0]  WSTRB_M,
   output logic                       WLAST_M,
   output logic                       WVALID_M,
   input  logic                       WREADY_M,
   input  logic [`AXI_ID_BITS-1:0]    BID_M,
   input  logic [1:0]                 BRESP_M,
   input  logic                       BVALID_M,
   output logic                       BREADY_M
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RADDR = 3'd1,
      S_RDATA = 3'd2,
      S_WADDR = 3'd3,
      S_WDATA = 3'd4,
      S_WRESP = 3'd5
   } state_t;

   state_t                     state_q, state_d;
   logic [`AXI_ADDR_BITS-1:0]  addr_q, addr_d;
   logic [`AXI_LEN_BITS-1:0]   len_q, len_d;
   logic [`AXI_LEN_BITS-1:0]   beat_cnt_q, beat_cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      beat_cnt_d = beat_cnt_q;
      req_ready  = 1'b0;
      wd_ready   = 1'b0;
      rd_data    = '0;
      rd_last    = 1'b0;
      rd_valid   = 1'b0;
      done       = 1'b0;
      ARID_M     = '0;
      ARADDR_M   = '0;
      ARLEN_M    = '0;
      ARSIZE_M   = '0;
      ARBURST_M  = 2'b00;
      ARVALID_M  = 1'b0;
      RREADY_M   = 1'b0;
      AWID_M     = '0;
      AWADDR_M   = '0;
      AWLEN_M    = '0;
      AWSIZE_M   = '0;
      AWBURST_M  = 2'b00;
      AWVALID_M  = 1'b0;
      WDATA_M    = '0;
      WSTRB_M    = '0;
      WLAST_M    = 1'b0;
      WVALID_M   = 1'b0;
      BREADY_M   = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d  = req_addr;
               len_d   = req_len;
               state_d = req_write ? S_WADDR : S_RADDR;
            end
         end
         S_RADDR: begin
            ARVALID_M = 1'b1;
            ARID_M    = MASTER_ID;
            ARADDR_M  = addr_q;
            ARLEN_M   = len_q;
            ARSIZE_M  = 3'b010;
            ARBURST_M = 2'b01;
            if (ARREADY_M) state_d = S_RDATA;
         end
         S_RDATA: begin
            // Pure passthrough so the core sees R beats with no added latency.
            rd_valid = RVALID_M;
            rd_data  = RDATA_M;
            rd_last  = RLAST_M;
            RREADY_M = rd_ready;
            if (RVALID_M && rd_ready && RLAST_M) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WADDR: begin
            AWVALID_M = 1'b1;
            AWID_M    = MASTER_ID;
            AWADDR_M  = addr_q;
            AWLEN_M   = len_q;
            AWSIZE_M  = 3'b010;
            AWBURST_M = 2'b01;
            if (AWREADY_M) state_d = S_WDATA;
         end
         S_WDATA: begin
            WVALID_M = wd_valid;
            WDATA_M  = wd_data;
            WSTRB_M  = wd_strb;
            WLAST_M  = (beat_cnt_q == len_q);
            wd_ready = WREADY_M;
            if (wd_valid && WREADY_M) begin
               if (beat_cnt_q == len_q) begin
                  beat_cnt_d = '0;
                  state_d    = S_WRESP;
               end else begin
                  beat_cnt_d = beat_cnt_q + `AXI_LEN_BITS'(1);
               end
            end
         end
         S_WRESP: begin
            BREADY_M = 1'b1;
            if (BVALID_M) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef AXI_MASTER_ERR_STICKY_EN
   logic err_q, err_d;
   logic unused_ok;

   // A new error in the same cycle as a clear request takes priority.
   always_comb begin
      err_d = err_q;
      if (err_clr) err_d = 1'b0;
      if ((state_q == S_RDATA && RVALID_M && rd_ready && RRESP_M != 2'b00) ||
          (state_q == S_WRESP && BVALID_M && BRESP_M != 2'b00))
         err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err       = err_q;
   assign unused_ok = ^{RID_M, BID_M};
`else
   logic unused_ok;
   assign err       = 1'b0;
   assign unused_ok = ^{RID_M, BID_M, RRESP_M, BRESP_M, err_clr};
`endif

endmodule

`default_nettype wire
